// File: rtl/capture_ctrl_pkg.sv
// rtl/capture_ctrl_pkg.sv - shared types and constants for the capture sequencer
package capture_ctrl_pkg;

    // Capture sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2,
        ST_READ  = 2'd3
    } capture_state_t;

    // Command decoder opcode that carries the read/delay count payload
    localparam logic [7:0] CMD_SET_CNT = 8'h81;

    // Samples represented by one unit of the read/delay count fields
    localparam int CNT_UNIT = 4;

endpackage

// File: rtl/capture_cnt.sv
// rtl/capture_cnt.sv - loadable down-counter with zero/one flags
module capture_cnt #(
    parameter int CNT_W = 19
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             one_o
);

    logic [CNT_W-1:0] cnt;

    // Count register: clear beats load, load beats decrement; never wraps below zero
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= load_val_i;
        end else if (dec_i && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_o = (cnt == '0);
    assign one_o  = (cnt == CNT_W'(1));

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - arm/trigger/post-delay/readout sequencer for the sample RAM
module capture_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 19
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cmd_i,
    input  logic              set_cnt_i,
    input  logic              exec_i,
    input  logic              arm_i,
    input  logic              run_i,
    input  logic              stb_i,
    input  logic              tx_ready_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic              rd_o,
    output logic [ADDR_W-1:0] raddr_o,
    output logic              armed_o,
    output logic              triggered_o,
    output logic              done_o
);

    // Buffer depth expressed in counter units, used to clamp the readout length
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(1) << ADDR_W;
    localparam logic [CNT_W-1:0] UNIT_C  = CNT_W'(CNT_UNIT);

    capture_state_t state, state_nxt;

    logic [ADDR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0]  r_delay, r_read;
    logic [CNT_W-1:0]  delay_req, read_raw, read_req;
    logic              done_q;

    logic cfg_en, capturing, wr_en, rd_en, rearm, trig, delay_end, read_end;
    logic dcnt_zero, dcnt_one, rcnt_zero, rcnt_one;

    // Count fields are in units of CNT_UNIT samples, stored as field+1
    assign delay_req = (CNT_W'(cmd_i[31:16]) + CNT_W'(1)) * UNIT_C;
    assign read_raw  = (CNT_W'(cmd_i[15:0])  + CNT_W'(1)) * UNIT_C;
    assign read_req  = (read_raw > DEPTH_C) ? DEPTH_C : read_raw;

    // Event decode shared by the FSM, counters and pointers
    always_comb begin
        cfg_en    = exec_i & set_cnt_i & (state == ST_IDLE);
        capturing = (state == ST_ARMED) || (state == ST_DELAY);
        wr_en     = capturing & stb_i;
        rd_en     = (state == ST_READ) & tx_ready_i;
        rearm     = capturing & arm_i;
        trig      = (state == ST_ARMED) & run_i & ~arm_i;
        // A counter should never sit at zero in DELAY/READ; treat zero as final
        delay_end = (state == ST_DELAY) & stb_i & ~arm_i & (dcnt_one | dcnt_zero);
        read_end  = rd_en & (rcnt_one | rcnt_zero);
    end

    // Post-trigger delay counter, counts strobes after the trigger sample
    capture_cnt #(.CNT_W(CNT_W)) u_delay_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (rearm),
        .load_i     (trig),
        .load_val_i (r_delay),
        .dec_i      ((state == ST_DELAY) & stb_i),
        .zero_o     (dcnt_zero),
        .one_o      (dcnt_one)
    );

    // Readout counter, counts accepted transmitter reads
    capture_cnt #(.CNT_W(CNT_W)) u_read_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (1'b0),
        .load_i     (delay_end),
        .load_val_i (r_read),
        .dec_i      (rd_en),
        .zero_o     (rcnt_zero),
        .one_o      (rcnt_one)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: re-arm has priority over trigger and delay completion
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (arm_i) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (arm_i)      state_nxt = ST_ARMED;
                else if (run_i) state_nxt = ST_DELAY;
            end
            ST_DELAY: begin
                if (arm_i)          state_nxt = ST_ARMED;
                else if (delay_end) state_nxt = ST_READ;
            end
            ST_READ: begin
                if (read_end) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; everything is forced low while reset is held
    always_comb begin
        we_o        = 1'b0;
        waddr_o     = '0;
        rd_o        = 1'b0;
        raddr_o     = '0;
        armed_o     = 1'b0;
        triggered_o = 1'b0;
        done_o      = 1'b0;
        if (!rst_i) begin
            we_o        = wr_en;
            waddr_o     = wptr;
            rd_o        = rd_en;
            raddr_o     = rptr;
            armed_o     = capturing;
            triggered_o = (state == ST_DELAY) || (state == ST_READ);
            done_o      = done_q;
        end
    end

    // Count configuration, write/read pointers and the done pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr    <= '0;
            rptr    <= '0;
            r_delay <= UNIT_C;
            r_read  <= UNIT_C;
            done_q  <= 1'b0;
        end else begin
            if (cfg_en) begin
                r_delay <= delay_req;
                r_read  <= read_req;
            end
            if (wr_en) begin
                wptr <= wptr + ADDR_W'(1);
            end
            // Readout starts at the newest sample, i.e. the address just written
            if (delay_end) begin
                rptr <= wptr;
            end else if (rd_en) begin
                rptr <= rptr - ADDR_W'(1);
            end
            done_q <= read_end;
        end
    end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Sequencing controller for the logic-analyzer capture path. Sits between the command decoder, the trigger unit and the sample RAM.
- Writes strobed samples into a circular buffer while armed. On the trigger's run flag it captures a programmed number of post-trigger samples.
- Then replays a programmed number of samples newest-first to the transmitter, using a ready handshake.

Parameters:
ADDR_W, 12, sample RAM address width; depth DEPTH = 2**ADDR_W samples
CNT_W, 19, width of internal delay/read counters (holds (0xFFFF+1)*4)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active high
cmd_i  in  32  command payload; [31:16] delay field, [15:0] read field
set_cnt_i  in  1  flag, command is "set read/delay count"
exec_i  in  1  execute command (qualifies set_cnt_i)
arm_i  in  1  flag, arm capture (same pulse also arms trigger unit)
run_i  in  1  trigger fired (from trigger unit)
stb_i  in  1  flag, new sample valid this cycle
tx_ready_i  in  1  transmitter can accept one sample read
we_o  out  1  sample RAM write enable
waddr_o  out  ADDR_W  sample RAM write address
rd_o  out  1  sample RAM read strobe (one sample handed to transmitter)
raddr_o  out  ADDR_W  sample RAM read address
armed_o  out  1  state is ARMED or DELAY
triggered_o  out  1  state is DELAY or READ
done_o  out  1  one-cycle pulse, capture readout complete

Behaviour:
- Reset: state=IDLE, wptr=0, rptr=0, r_delay=4, r_read=4, counters=0. All outputs 0.
- Count config: when exec_i & set_cnt_i in IDLE, latch:
  - r_delay = (cmd_i[31:16]+1)*4
  - r_read = min((cmd_i[15:0]+1)*4, DEPTH)
  - Ignored in any other state.
- FSM states: IDLE, ARMED, DELAY, READ.
- IDLE -> ARMED on arm_i. wptr is kept (not cleared).
- ARMED:
  - we_o = stb_i; waddr_o = wptr; on stb_i, wptr <= wptr+1 modulo DEPTH (wrap, no overflow flag).
  - On run_i -> DELAY, dcnt <= r_delay. The sample strobed in the run_i cycle is written but not counted toward the delay.
- DELAY:
  - Writes as in ARMED. Each stb_i decrements dcnt.
  - stb_i with dcnt==1 -> READ, with rptr <= wptr (pre-increment value = last written address) and rcnt <= r_read.
  - run_i has no effect in DELAY.
- READ:
  - we_o=0. rd_o = tx_ready_i (combinational); raddr_o = rptr.
  - On rd_o: rptr <= rptr-1 modulo DEPTH; rcnt decrements.
  - rd_o with rcnt==1 -> IDLE, and done_o is asserted the following cycle for exactly 1 cycle.
  - stb_i ignored.
- arm_i in ARMED or DELAY: return to ARMED, dcnt cleared, wptr kept (re-arm restarts trigger wait). arm_i in READ: ignored.
- Simultaneous arm_i and run_i in ARMED: arm_i wins, stay ARMED.
- Simultaneous exec_i and arm_i in IDLE: counts latch and state goes ARMED in the same cycle; the new counts apply.
- rst_i mid-operation: immediate return to reset values. No done_o.
- Latency:
  - write: combinational from stb_i.
  - trigger to DELAY: 1 cycle.
  - last delay stb_i to first possible rd_o: 1 cycle.
- Pre-trigger depth is implicit: it is the RAM contents older than the post-trigger samples. Readout may include stale or unwritten entries if fewer than r_read samples were captured. This is accepted and not flagged.

Decomposition:
- logIP_pkg gains:
  - capture_state_t enum (IDLE, ARMED, DELAY, READ)
  - CMD_SET_CNT opcode constant
  - CNT_UNIT = 4 (samples per count unit)
- One natural sub-module: capture_cnt, a loadable down-counter with zero/one flag. Instantiated twice (delay, read).

Test Plan:
- Reset: drive rst_i 3 cycles with random inputs -> all outputs 0 throughout and on the first cycle after release.
- Basic capture (ADDR_W=12), cmd 0x0001_0001 (delay=8, read=8):
  - Stimulus: arm, 5 stb, run+stb, 8 stb.
  - Writes: 14 we_o pulses, waddr 0..13; triggered_o rises the cycle after run_i.
  - Readout with tx_ready_i=1: rd_o 8 consecutive cycles, raddr 13,12,...,6; done_o one cycle later; then IDLE.
- Wrap and clamp (ADDR_W=4), cmd 0x0000_0007 (delay=4, read=32, clamped to 16):
  - Stimulus: arm, 20 stb, run+stb, 4 stb.
  - Writes: waddr wraps 15->0; last written addr 8.
  - Readout: exactly 16 rd_o, raddr 8 down to 0, then 15 down to 9.
- Handshake stall: in READ, toggle tx_ready_i 1,0,0,1,… -> rd_o mirrors tx_ready_i; raddr_o holds while low; total rd_o count equals r_read.
- Re-arm and ignore rules:
  - arm_i during DELAY -> back to ARMED; the next run_i restarts a full delay of r_delay strobes.
  - set_cnt in ARMED -> r_delay/r_read unchanged (verified by next capture length).
  - arm_i in READ -> no effect.
- Reset mid-READ: assert rst_i after 3 of 8 reads -> rd_o 0 next cycle, done_o never pulses, waddr_o=0.
